// File: rtl/reg_pkg.sv
// Shared register-file types and default sizes (used by reg_file and reg_wb_ctrl).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package reg_pkg;

  localparam int n_regs_c  = 32;
  localparam int wd_regs_c = 32;
  localparam int wd_addr_c = $clog2(n_regs_c);

  typedef logic [wd_addr_c-1:0] reg_addr_t;
  typedef logic [wd_regs_c-1:0] reg_data_t;

endpackage : reg_pkg

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
// Latency: grant is combinational from i_req; the pointer advances on the edge after i_fire.
// Backpressure: the pointer holds while nothing fires, so a waiting requester keeps its priority.
module rr_arbiter #(
  parameter int n_req_p = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [n_req_p-1:0] i_req,
  input  logic               i_fire,
  output logic [n_req_p-1:0] o_gnt
);

  localparam int wd_ptr_lp = (n_req_p > 1) ? $clog2(n_req_p) : 1;

  logic [wd_ptr_lp-1:0] r_ptr;
  logic [wd_ptr_lp-1:0] w_idx;
  logic [n_req_p-1:0]   w_gnt;
  logic                 w_found;

  // Search r_ptr, r_ptr+1, ... (mod n_req_p) for the first active request.
  always_comb begin
    w_gnt   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int off = 0; off < n_req_p; off++) begin
      for (int j = 0; j < n_req_p; j++) begin
        if (!w_found && i_req[j] &&
            (((int'(r_ptr) + off) >= n_req_p ? (int'(r_ptr) + off - n_req_p)
                                             : (int'(r_ptr) + off)) == j)) begin
          w_gnt[j] = 1'b1;
          w_idx    = wd_ptr_lp'(j);
          w_found  = 1'b1;
        end
      end
    end
  end

  // Pointer moves just past the winner on a transfer, wrapping at the last requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_fire) begin
      r_ptr <= (w_idx == wd_ptr_lp'(n_req_p - 1)) ? '0 : w_idx + 1'b1;
    end
  end

  assign o_gnt = w_gnt;

endmodule : rr_arbiter

// File: rtl/reg_wb_ctrl.sv
// Writeback controller: arbitrates execute-unit writebacks onto the reg_file write port and scoreboards pending writes.
// Latency: grant combinational; reg_file write one cycle after the transfer; busy bit clears with that write.
// Backpressure: one requester is granted per cycle; the others hold valid/addr/data until their ready.
module reg_wb_ctrl
  import reg_pkg::*;
#(
  parameter  int n_req_p   = 3,
  parameter  int n_regs_p  = n_regs_c,
  parameter  int wd_regs_p = wd_regs_c,
  parameter  int n_chk_p   = 2,
  localparam int wd_addr_p = $clog2(n_regs_p)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [n_req_p-1:0]                  i_wb_valid,
  output logic [n_req_p-1:0]                  o_wb_ready,
  input  logic [n_req_p-1:0][wd_addr_p-1:0]   i_wb_addr,
  input  logic [n_req_p-1:0][wd_regs_p-1:0]   i_wb_data,
  output logic                                o_reg_wr_en,
  output logic [wd_addr_p-1:0]                o_reg_wr_addr,
  output logic [wd_regs_p-1:0]                o_reg_wr_data,
  input  logic                                i_issue_en,
  input  logic [wd_addr_p-1:0]                i_issue_rd,
  input  logic [n_chk_p-1:0][wd_addr_p-1:0]   i_chk_addr,
  output logic [n_chk_p-1:0]                  o_chk_busy,
  output logic [n_regs_p-1:0]                 o_busy_vec
);

  logic [n_req_p-1:0]   w_req;
  logic [n_req_p-1:0]   w_gnt;
  logic                 w_fire;
  logic [wd_addr_p-1:0] w_sel_addr;
  logic [wd_regs_p-1:0] w_sel_data;
  logic [n_regs_p-1:0]  w_set;
  logic [n_regs_p-1:0]  w_clr;
  logic [n_regs_p-1:0]  w_busy_nxt;

  logic                 r_wr_en;
  logic [wd_addr_p-1:0] r_wr_addr;
  logic [wd_regs_p-1:0] r_wr_data;
  logic [n_regs_p-1:0]  r_busy;

  // Nothing is granted while reset is held, even with valids asserted.
  assign w_req  = i_wb_valid & {n_req_p{rst_n}};
  assign w_fire = |(w_req & w_gnt);

  rr_arbiter #(
    .n_req_p (n_req_p)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_req  (w_req),
    .i_fire (w_fire),
    .o_gnt  (w_gnt)
  );

  assign o_wb_ready = w_gnt;

  // One-hot AND-OR mux of the granted requester's address and data.
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int r = 0; r < n_req_p; r++) begin
      if (w_gnt[r]) begin
        w_sel_addr = w_sel_addr | i_wb_addr[r];
        w_sel_data = w_sel_data | i_wb_data[r];
      end
    end
  end

  // Registered write port; x0 writes are accepted upstream but never enabled here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (w_fire) begin
      r_wr_en   <= (w_sel_addr != '0);
      r_wr_addr <= w_sel_addr;
      r_wr_data <= w_sel_data;
    end else begin
      r_wr_en   <= 1'b0;
    end
  end

  // Set from issue, clear from the write that reg_file captures this edge; set wins, x0 never busy.
  assign w_set      = (i_issue_en && (i_issue_rd != '0)) ? (n_regs_p'(1) << i_issue_rd) : '0;
  assign w_clr      = r_wr_en ? (n_regs_p'(1) << r_wr_addr) : '0;
  assign w_busy_nxt = ((r_busy & ~w_clr) | w_set) & ~n_regs_p'(1);

  // Pending-write scoreboard flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Hazard lookups see registered state only; bit 0 is always clear so x0 reads not-busy.
  always_comb begin
    o_chk_busy = '0;
    for (int i = 0; i < n_chk_p; i++) begin
      o_chk_busy[i] = r_busy[i_chk_addr[i]];
    end
  end

  assign o_reg_wr_en   = r_wr_en;
  assign o_reg_wr_addr = r_wr_addr;
  assign o_reg_wr_data = r_wr_data;
  assign o_busy_vec    = r_busy;

endmodule : reg_wb_ctrl

// File: tb/tb_reg_wb_ctrl.sv
// Directed bench for reg_wb_ctrl: reset, fairness, sparse, x0, scoreboard, set/clear collision, mid-burst reset.
// Latency: checks sampled on the falling edge, inputs driven 1 time unit after the rising edge.
// Backpressure: requesters drop valid after their granted cycle.
module tb_reg_wb_ctrl;

  logic             clk;
  logic             rst_n;
  logic [2:0]       wb_valid;
  logic [2:0]       wb_ready;
  logic [2:0][4:0]  wb_addr;
  logic [2:0][31:0] wb_data;
  logic             wr_en;
  logic [4:0]       wr_addr;
  logic [31:0]      wr_data;
  logic             issue_en;
  logic [4:0]       issue_rd;
  logic [1:0][4:0]  chk_addr;
  logic [1:0]       chk_busy;
  logic [31:0]      busy_vec;

  int total = 0;
  int bad   = 0;

  reg_wb_ctrl #(
    .n_req_p   (3),
    .n_regs_p  (32),
    .wd_regs_p (32),
    .n_chk_p   (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_wb_valid    (wb_valid),
    .o_wb_ready    (wb_ready),
    .i_wb_addr     (wb_addr),
    .i_wb_data     (wb_data),
    .o_reg_wr_en   (wr_en),
    .o_reg_wr_addr (wr_addr),
    .o_reg_wr_data (wr_data),
    .i_issue_en    (issue_en),
    .i_issue_rd    (issue_rd),
    .i_chk_addr    (chk_addr),
    .o_chk_busy    (chk_busy),
    .o_busy_vec    (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issuing to a register that is still pending is a WAW the issue logic must never produce.
  always @(posedge clk) begin
    if (rst_n && issue_en && issue_rd != 5'd0 && busy_vec[issue_rd])
      $error("WAW issue to busy register %0d", issue_rd);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    issue_en = 1'b0;
    issue_rd = 5'd0;
    chk_addr[0] = 5'd0;
    chk_addr[1] = 5'd0;
    wb_valid = 3'b111;
    wb_addr[0] = 5'd1; wb_data[0] = 32'h100;
    wb_addr[1] = 5'd2; wb_data[1] = 32'h200;
    wb_addr[2] = 5'd3; wb_data[2] = 32'h300;

    // Reset held with all valids high.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",   wb_ready, 3'b000);
    chk("rst_wr_en",   wr_en,    1'b0);
    chk("rst_wr_addr", wr_addr,  5'd0);
    chk("rst_wr_data", wr_data,  32'h0);
    chk("rst_busy",    busy_vec, 32'h0);

    // Fairness: six back-to-back grants r0,r1,r2,r0,r1,r2.
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("fair_gnt", wb_ready, 64'(3'b001 << (k % 3)));
      if (k > 0) begin
        chk("fair_wr_en",   wr_en,   1'b1);
        chk("fair_wr_addr", wr_addr, 64'(((k - 1) % 3) + 1));
        chk("fair_wr_data", wr_data, 64'((((k - 1) % 3) + 1) * 32'h100));
      end else begin
        chk("fair_wr_en0", wr_en, 1'b0);
      end
      step();
    end
    wb_valid = 3'b000;
    @(negedge clk);
    chk("fair_last_ready", wb_ready, 3'b000);
    chk("fair_last_en",    wr_en,    1'b1);
    chk("fair_last_addr",  wr_addr,  5'd3);
    chk("fair_last_data",  wr_data,  32'h300);
    step();
    @(negedge clk);
    chk("idle_wr_en", wr_en, 1'b0);

    // Sparse: only r2, granted the same cycle.
    wb_valid = 3'b100;
    wb_addr[2] = 5'd5; wb_data[2] = 32'hDEADBEEF;
    @(negedge clk);
    chk("sparse_ready", wb_ready, 3'b100);
    step();
    wb_valid = 3'b000;
    @(negedge clk);
    chk("sparse_wr_en",   wr_en,   1'b1);
    chk("sparse_wr_addr", wr_addr, 5'd5);
    chk("sparse_wr_data", wr_data, 32'hDEADBEEF);

    // x0 write: accepted but not written, scoreboard untouched.
    step();
    wb_valid = 3'b010;
    wb_addr[1] = 5'd0; wb_data[1] = 32'h1234;
    @(negedge clk);
    chk("x0_ready", wb_ready, 3'b010);
    step();
    wb_valid = 3'b000;
    @(negedge clk);
    chk("x0_wr_en", wr_en,    1'b0);
    chk("x0_busy",  busy_vec, 32'h0);

    // Scoreboard: issue x7, then write it back.
    step();
    issue_en = 1'b1; issue_rd = 5'd7;
    chk_addr[0] = 5'd7; chk_addr[1] = 5'd0;
    @(negedge clk);
    chk("sb_no_bypass", chk_busy, 2'b00);
    step();
    issue_en = 1'b0;
    @(negedge clk);
    chk("sb_set_chk",  chk_busy, 2'b01);
    chk("sb_set_vec",  busy_vec, 32'h80);
    step();
    wb_valid = 3'b001;
    wb_addr[0] = 5'd7; wb_data[0] = 32'hCAFE;
    @(negedge clk);
    chk("sb_wb_ready", wb_ready, 3'b001);
    chk("sb_wb_busy",  chk_busy, 2'b01);
    step();
    wb_valid = 3'b000;
    @(negedge clk);
    chk("sb_t1_wr_en", wr_en,    1'b1);
    chk("sb_t1_addr",  wr_addr,  5'd7);
    chk("sb_t1_data",  wr_data,  32'hCAFE);
    chk("sb_t1_busy",  chk_busy, 2'b01);
    step();
    @(negedge clk);
    chk("sb_t2_busy",  chk_busy, 2'b00);
    chk("sb_t2_vec",   busy_vec, 32'h0);
    chk("sb_t2_wr_en", wr_en,    1'b0);

    // Set/clear collision on x9: set wins.
    step();
    wb_valid = 3'b010;
    wb_addr[1] = 5'd9; wb_data[1] = 32'h99;
    chk_addr[1] = 5'd9;
    @(negedge clk);
    chk("col_ready", wb_ready, 3'b010);
    step();
    wb_valid = 3'b000;
    issue_en = 1'b1; issue_rd = 5'd9;
    @(negedge clk);
    chk("col_wr_en", wr_en,   1'b1);
    chk("col_addr",  wr_addr, 5'd9);
    step();
    issue_en = 1'b0;
    @(negedge clk);
    chk("col_vec", busy_vec, 32'h200);
    chk("col_chk", chk_busy, 2'b10);

    // Mid-burst asynchronous reset; pointer must return to r0.
    step();
    wb_valid = 3'b111;
    wb_addr[0] = 5'd1; wb_data[0] = 32'h100;
    wb_addr[1] = 5'd2; wb_data[1] = 32'h200;
    wb_addr[2] = 5'd3; wb_data[2] = 32'h300;
    @(negedge clk);
    chk("mb_gnt0", wb_ready, 3'b100);
    step();
    @(negedge clk);
    chk("mb_gnt1",  wb_ready, 3'b001);
    chk("mb_wr1",   wr_addr,  5'd3);
    step();
    @(negedge clk);
    chk("mb_gnt2",  wb_ready, 3'b010);
    chk("mb_wr_en", wr_en,    1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_ready",   wb_ready, 3'b000);
    chk("arst_wr_en",   wr_en,    1'b0);
    chk("arst_wr_addr", wr_addr,  5'd0);
    chk("arst_wr_data", wr_data,  32'h0);
    chk("arst_busy",    busy_vec, 32'h0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_ptr", wb_ready, 3'b001);
    chk("arst_idle_en", wr_en, 1'b0);
    step();
    wb_valid = 3'b000;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_reg_wb_ctrl
